// File: rtl/reg_file_param.sv
// reg_file_param: parametrised MIPS general-purpose register file.
// Two registered read ports with write-to-read forwarding, an optional
// hardwired zero register, a stall hold input and a one-cycle debug read port.
//
// Debug handshake: dbg_req has no backpressure. Each edge that samples
// dbg_req=1 yields exactly one cycle of dbg_valid=1 on the following cycle,
// with dbg_data qualified by dbg_valid. dbg_data holds its last value while
// dbg_valid is low.
module reg_file_param #(
   parameter int DATA_W   = 32,
   parameter int DEPTH    = 32,
   parameter int ADDR_W   = 5,
   parameter int ZERO_REG = 1,
   parameter int BYPASS   = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] rs_addr,
   input  logic [ADDR_W-1:0] rt_addr,
   input  logic [ADDR_W-1:0] rd_addr,
   input  logic [DATA_W-1:0] rd_data,
   input  logic              write_en,
   input  logic              hold,
   output logic [DATA_W-1:0] rs_data,
   output logic [DATA_W-1:0] rt_data,
   input  logic              dbg_req,
   input  logic [ADDR_W-1:0] dbg_addr,
   output logic              dbg_valid,
   output logic [DATA_W-1:0] dbg_data
);

   // One extra bit so DEPTH = 2^ADDR_W still compares correctly.
   localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
   localparam bit ZR = (ZERO_REG != 0);
   localparam bit BP = (BYPASS != 0);

   logic [DATA_W-1:0] regs [DEPTH];
   logic [ADDR_W-1:0] rs_cap;
   logic [ADDR_W-1:0] rt_cap;

   logic              wr_eff;
   logic [DATA_W-1:0] rs_next;
   logic [DATA_W-1:0] rt_next;
   logic [DATA_W-1:0] dbg_next;
   logic              rs_hit;
   logic              rt_hit;

   // Value a read of address a returns on this edge, including forwarding of
   // an effective write and the zero / out-of-range rules.
   function automatic logic [DATA_W-1:0] read_val(input logic [ADDR_W-1:0] a);
      logic [DATA_W-1:0] v;
      v = '0;
      if (({1'b0, a} < DEPTH_L) && !(ZR && (a == '0))) begin
         if (BP && wr_eff && (rd_addr == a))
            v = rd_data;
         else
            v = regs[a];
      end
      return v;
   endfunction

   // A write only counts when it lands in a real, writable entry.
   always_comb begin
      wr_eff = write_en && ({1'b0, rd_addr} < DEPTH_L) && !(ZR && (rd_addr == '0));
   end

   // Next-state read values for both ports and the debug port; hit flags
   // refresh a held output when its captured register is overwritten.
   always_comb begin
      rs_next  = read_val(rs_addr);
      rt_next  = read_val(rt_addr);
      dbg_next = read_val(dbg_addr);
      rs_hit   = BP && wr_eff && (rd_addr == rs_cap);
      rt_hit   = BP && wr_eff && (rd_addr == rt_cap);
   end

   // Register storage: cleared on reset, written from write-back.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++)
            regs[i] <= '0;
      end else if (wr_eff) begin
         regs[rd_addr] <= rd_data;
      end
   end

   // Read ports: capture address and data unless stalled; during a stall
   // only a write to the captured register may refresh the output.
   always_ff @(posedge clk) begin
      if (reset) begin
         rs_cap  <= '0;
         rt_cap  <= '0;
         rs_data <= '0;
         rt_data <= '0;
      end else if (!hold) begin
         rs_cap  <= rs_addr;
         rt_cap  <= rt_addr;
         rs_data <= rs_next;
         rt_data <= rt_next;
      end else begin
         if (rs_hit)
            rs_data <= rd_data;
         if (rt_hit)
            rt_data <= rd_data;
      end
   end

   // Debug port: one valid pulse per request, independent of hold.
   always_ff @(posedge clk) begin
      if (reset) begin
         dbg_valid <= 1'b0;
         dbg_data  <= '0;
      end else begin
         dbg_valid <= dbg_req;
         if (dbg_req)
            dbg_data <= dbg_next;
      end
   end

endmodule

// File: tb/tb_reg_file_param.sv
// tb_reg_file_param: vector bench for reg_file_param. Two instances share
// all inputs: u_a uses the defaults (32 entries, zero register, forwarding),
// u_b uses DEPTH=24, no zero register, no forwarding.
module tb_reg_file_param;

   localparam int W  = 32;
   localparam int AW = 5;
   localparam int EW = 6*W + 1;

   logic          clk;
   logic          reset;
   logic [AW-1:0] rs_addr, rt_addr, rd_addr, dbg_addr;
   logic [W-1:0]  rd_data;
   logic          write_en, hold, dbg_req;
   logic [W-1:0]  rs_a, rt_a, dd_a, rs_b, rt_b, dd_b;
   logic          dv_a, dv_b;

   logic [EW-1:0] exp_q[$];
   int            n_checks = 0;
   int            n_pass   = 0;

   typedef struct {
      logic          rst;
      logic          we;
      logic [AW-1:0] wa;
      logic [W-1:0]  wd;
      logic [AW-1:0] rs;
      logic [AW-1:0] rt;
      logic          hold;
      logic          dreq;
      logic [AW-1:0] da;
      logic [W-1:0]  e_rs_a;
      logic [W-1:0]  e_rt_a;
      logic          e_dv;
      logic [W-1:0]  e_dd_a;
      logic [W-1:0]  e_rs_b;
      logic [W-1:0]  e_rt_b;
      logic [W-1:0]  e_dd_b;
   } vec_t;

   vec_t vecs[13];

   reg_file_param u_a (
      .clk(clk), .reset(reset), .rs_addr(rs_addr), .rt_addr(rt_addr),
      .rd_addr(rd_addr), .rd_data(rd_data), .write_en(write_en), .hold(hold),
      .rs_data(rs_a), .rt_data(rt_a), .dbg_req(dbg_req), .dbg_addr(dbg_addr),
      .dbg_valid(dv_a), .dbg_data(dd_a)
   );

   reg_file_param #(.DATA_W(32), .DEPTH(24), .ADDR_W(5), .ZERO_REG(0), .BYPASS(0)) u_b (
      .clk(clk), .reset(reset), .rs_addr(rs_addr), .rt_addr(rt_addr),
      .rd_addr(rd_addr), .rd_data(rd_data), .write_en(write_en), .hold(hold),
      .rs_data(rs_b), .rt_data(rt_b), .dbg_req(dbg_req), .dbg_addr(dbg_addr),
      .dbg_valid(dv_b), .dbg_data(dd_b)
   );

   // clock / reset idle levels
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      reset    = 1'b1;
      write_en = 1'b0;
      hold     = 1'b0;
      dbg_req  = 1'b0;
      rs_addr  = '0;
      rt_addr  = '0;
      rd_addr  = '0;
      dbg_addr = '0;
      rd_data  = '0;
   end

   // watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required end before 200000");
      $fatal(1, "timeout");
   end

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_checks++;
      if (act !== exp)
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      else
         n_pass++;
   endtask

   // scoreboard: pop one expected record and compare against both instances
   task automatic compare_out();
      logic [EW-1:0] e;
      if (exp_q.size() == 0) begin
         n_checks++;
         $display("FAIL scoreboard: queue empty, got 0 entries expected 1");
         return;
      end
      e = exp_q.pop_front();
      check("rs_a",  rs_a, e[6*W:5*W+1]);
      check("rt_a",  rt_a, e[5*W:4*W+1]);
      check("dv_a",  {31'b0, dv_a}, {31'b0, e[4*W]});
      check("dv_b",  {31'b0, dv_b}, {31'b0, e[4*W]});
      check("dd_a",  dd_a, e[4*W-1:3*W]);
      check("rs_b",  rs_b, e[3*W-1:2*W]);
      check("rt_b",  rt_b, e[2*W-1:W]);
      check("dd_b",  dd_b, e[W-1:0]);
   endtask

   // driver: apply one cycle of inputs, queue the expected outputs, check after the edge
   task automatic step(input logic r, input logic w, input logic [AW-1:0] wa, input logic [W-1:0] wd,
                       input logic [AW-1:0] ra, input logic [AW-1:0] rb, input logic h,
                       input logic dq, input logic [AW-1:0] da,
                       input logic [W-1:0] ers, input logic [W-1:0] ert, input logic edv,
                       input logic [W-1:0] edd, input logic [W-1:0] ersb,
                       input logic [W-1:0] ertb, input logic [W-1:0] eddb);
      @(negedge clk);
      reset    = r;
      write_en = w;
      rd_addr  = wa;
      rd_data  = wd;
      rs_addr  = ra;
      rt_addr  = rb;
      hold     = h;
      dbg_req  = dq;
      dbg_addr = da;
      exp_q.push_back({ers, ert, edv, edd, ersb, ertb, eddb});
      @(posedge clk);
      #1;
      compare_out();
   endtask

   initial begin
      // rst we wa wd rs rt hold dreq da | rs_a rt_a dv dd_a | rs_b rt_b dd_b
      vecs[0]  = '{1'b1, 1'b0, 5'd0,  32'h0,        5'd0,  5'd0,  1'b0, 1'b0, 5'd0,
                   32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0};
      vecs[1]  = '{1'b0, 1'b1, 5'd5,  32'hDEADBEEF, 5'd0,  5'd0,  1'b0, 1'b0, 5'd0,
                   32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0};
      // reset wins over write, dbg_req
      vecs[2]  = '{1'b1, 1'b1, 5'd5,  32'h1,        5'd5,  5'd5,  1'b0, 1'b1, 5'd5,
                   32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0};
      vecs[3]  = '{1'b0, 1'b0, 5'd0,  32'h0,        5'd5,  5'd31, 1'b0, 1'b1, 5'd5,
                   32'h0, 32'h0, 1'b1, 32'h0, 32'h0, 32'h0, 32'h0};
      // same-edge write and read of r7 on both ports and debug
      vecs[4]  = '{1'b0, 1'b1, 5'd7,  32'h12345678, 5'd7,  5'd7,  1'b0, 1'b1, 5'd7,
                   32'h12345678, 32'h12345678, 1'b1, 32'h12345678, 32'h0, 32'h0, 32'h0};
      vecs[5]  = '{1'b0, 1'b0, 5'd0,  32'h0,        5'd7,  5'd0,  1'b0, 1'b0, 5'd0,
                   32'h12345678, 32'h0, 1'b0, 32'h12345678, 32'h12345678, 32'h0, 32'h0};
      // zero register
      vecs[6]  = '{1'b0, 1'b1, 5'd0,  32'hFFFFFFFF, 5'd0,  5'd0,  1'b0, 1'b1, 5'd0,
                   32'h0, 32'h0, 1'b1, 32'h0, 32'h0, 32'h0, 32'h0};
      vecs[7]  = '{1'b0, 1'b0, 5'd0,  32'h0,        5'd0,  5'd7,  1'b0, 1'b1, 5'd0,
                   32'h0, 32'h12345678, 1'b1, 32'h0, 32'hFFFFFFFF, 32'h12345678, 32'hFFFFFFFF};
      // addresses beyond DEPTH=24 on u_b
      vecs[8]  = '{1'b0, 1'b1, 5'd30, 32'hAA,       5'd30, 5'd23, 1'b0, 1'b0, 5'd0,
                   32'hAA, 32'h0, 1'b0, 32'h0, 32'h0, 32'h0, 32'hFFFFFFFF};
      vecs[9]  = '{1'b0, 1'b1, 5'd23, 32'hBB,       5'd30, 5'd23, 1'b0, 1'b1, 5'd30,
                   32'hAA, 32'hBB, 1'b1, 32'hAA, 32'h0, 32'h0, 32'h0};
      vecs[10] = '{1'b0, 1'b0, 5'd0,  32'h0,        5'd23, 5'd30, 1'b0, 1'b1, 5'd23,
                   32'hBB, 32'hAA, 1'b1, 32'hBB, 32'hBB, 32'h0, 32'hBB};
      vecs[11] = '{1'b0, 1'b1, 5'd3,  32'h11,       5'd3,  5'd3,  1'b0, 1'b0, 5'd0,
                   32'h11, 32'h11, 1'b0, 32'hBB, 32'h0, 32'h0, 32'hBB};
      vecs[12] = '{1'b0, 1'b0, 5'd0,  32'h0,        5'd1,  5'd3,  1'b0, 1'b0, 5'd0,
                   32'h0, 32'h11, 1'b0, 32'hBB, 32'h0, 32'h11, 32'hBB};

      for (int i = 0; i < 13; i++)
         step(vecs[i].rst, vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].rs, vecs[i].rt,
              vecs[i].hold, vecs[i].dreq, vecs[i].da, vecs[i].e_rs_a, vecs[i].e_rt_a,
              vecs[i].e_dv, vecs[i].e_dd_a, vecs[i].e_rs_b, vecs[i].e_rt_b, vecs[i].e_dd_b);

      // hold sequence: captured rs=1, rt=3; debug still serviced under hold
      step(1'b0, 1'b0, 5'd0, 32'h0,  5'd9, 5'd9, 1'b1, 1'b1, 5'd3,
           32'h0, 32'h11, 1'b1, 32'h11, 32'h0, 32'h11, 32'h11);
      // write to an address that is not captured: no change
      step(1'b0, 1'b1, 5'd9, 32'h99, 5'd9, 5'd9, 1'b1, 1'b0, 5'd0,
           32'h0, 32'h11, 1'b0, 32'h11, 32'h0, 32'h11, 32'h11);
      // write to captured rt: refreshed with forwarding, frozen without
      step(1'b0, 1'b1, 5'd3, 32'h22, 5'd9, 5'd9, 1'b1, 1'b0, 5'd0,
           32'h0, 32'h22, 1'b0, 32'h11, 32'h0, 32'h11, 32'h11);
      step(1'b0, 1'b0, 5'd0, 32'h0,  5'd3, 5'd9, 1'b0, 1'b0, 5'd0,
           32'h22, 32'h99, 1'b0, 32'h11, 32'h22, 32'h99, 32'h11);
      // write to captured rs during hold
      step(1'b0, 1'b1, 5'd3, 32'h33, 5'd0, 5'd0, 1'b1, 1'b0, 5'd0,
           32'h33, 32'h99, 1'b0, 32'h11, 32'h22, 32'h99, 32'h11);

      // debug back-to-back: r1=5, r2=6, requests for 1 then 2
      step(1'b0, 1'b1, 5'd1, 32'h5,  5'd1, 5'd2, 1'b0, 1'b0, 5'd0,
           32'h5, 32'h0, 1'b0, 32'h11, 32'h0, 32'h0, 32'h11);
      step(1'b0, 1'b1, 5'd2, 32'h6,  5'd1, 5'd2, 1'b0, 1'b1, 5'd1,
           32'h5, 32'h6, 1'b1, 32'h5, 32'h5, 32'h0, 32'h5);
      step(1'b0, 1'b0, 5'd0, 32'h0,  5'd1, 5'd2, 1'b0, 1'b1, 5'd2,
           32'h5, 32'h6, 1'b1, 32'h6, 32'h5, 32'h6, 32'h6);
      step(1'b0, 1'b0, 5'd0, 32'h0,  5'd1, 5'd2, 1'b0, 1'b0, 5'd1,
           32'h5, 32'h6, 1'b0, 32'h6, 32'h5, 32'h6, 32'h6);

      // reset beats hold, write and dbg_req; contents cleared afterwards
      step(1'b1, 1'b1, 5'd3, 32'h7,  5'd1, 5'd2, 1'b1, 1'b1, 5'd3,
           32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
      step(1'b0, 1'b0, 5'd0, 32'h0,  5'd3, 5'd1, 1'b0, 1'b1, 5'd3,
           32'h0, 32'h0, 1'b1, 32'h0, 32'h0, 32'h0, 32'h0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/reg_file_param.md
Name: reg_file_param

Overview:
Parametrised general-purpose register file for the MIPS datapath, succeeding the fixed 32x32 file. It provides configurable data width and depth, two registered read ports with write-to-read bypass, an optional hardwired zero register, and a read-hold input for pipeline stalls. It also has a one-cycle debug read port. It sits in the decode stage, with writes arriving from write-back.

Parameters:
DATA_W, 32, width of each register in bits
DEPTH, 32, number of registers (2..256, need not be a power of 2)
ADDR_W, 5, address width; must satisfy 2^ADDR_W >= DEPTH
ZERO_REG, 1, when 1 register 0 always reads 0 and ignores writes
BYPASS, 1, when 1 a same-cycle write to the read address is forwarded to the read output

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  synchronous, active-high
rs_addr  in  ADDR_W  read port A address
rt_addr  in  ADDR_W  read port B address
rd_addr  in  ADDR_W  write address
rd_data  in  DATA_W  write data
write_en  in  1  write strobe
hold  in  1  stall: freeze read outputs
rs_data  out  DATA_W  read port A data, registered
rt_data  out  DATA_W  read port B data, registered
dbg_req  in  1  debug read request
dbg_addr  in  ADDR_W  debug read address
dbg_valid  out  1  debug data valid pulse
dbg_data  out  DATA_W  debug read data

Behaviour:
- Reset (synchronous, active-high): on a clock edge with reset=1, all DEPTH entries become 0. rs_data, rt_data, dbg_data and dbg_valid also become 0, and the captured read addresses become 0. Reset has priority over write_en, hold and dbg_req in that cycle.
- Write: on an edge with write_en=1, the entry at rd_addr takes the value of rd_data. The write is ignored in two cases: rd_addr >= DEPTH, or ZERO_REG=1 with rd_addr=0.
- Read latency is 1 cycle. When hold=0, each port captures its address (rs_addr or rt_addr) and loads its output with that entry's value on the edge.
- Bypass, with BYPASS=1: if an effective write (not ignored) targets the address being read on the same edge, the output loads the new rd_data. With BYPASS=0 the output loads the pre-write contents.
- Reads of an address >= DEPTH return 0. With ZERO_REG=1, reads of address 0 return 0.
- Hold: when hold=1, the captured addresses and outputs keep their values, with one exception. If an effective write hits a port's captured address, that port's output updates to rd_data on the same edge. This update happens only when BYPASS=1; with BYPASS=0 the output freezes exactly. This prevents stale operands after a stall.
- Both read ports may use the same address, and both are then updated or bypassed identically.
- Debug port: dbg_req=1 on an edge causes dbg_valid=1 and dbg_data=entry[dbg_addr] on the next cycle. Bypass applies identically. Out-of-range and zero-register addresses return 0. With dbg_req=0, dbg_valid returns to 0 on the next edge and dbg_data holds. Back-to-back requests give back-to-back valid cycles. dbg_req is ignored by hold.
- Entries are DATA_W wide with no width conversion. rd_data is stored unmodified.
- No combinational path from inputs to outputs.

Test Plan:
- Reset then read: assert reset for 1 cycle after writing 0xDEADBEEF to r5; read r5 and r31 → both 0 one cycle after the address is applied.
- Write/read with bypass: write_en=1, rd_addr=7, rd_data=0x12345678, with rs_addr=7 on the same edge → rs_data=0x12345678 on the next cycle. With BYPASS=0 → old value 0, then 0x12345678 one cycle later.
- Zero register: write 0xFFFFFFFF to r0 → rs_data=0, and dbg_data=0 with dbg_valid=1. With ZERO_REG=0 → reads 0xFFFFFFFF.
- Hold refresh: capture rt_addr=3 (value 0x11), then raise hold for 3 cycles and change rt_addr to 9. rt_data stays 0x11. A write of 0x22 to r3 during hold gives rt_data=0x22 on the next cycle. A write to r9 leaves rt_data unchanged.
- Non-power-of-2 depth: DEPTH=24, write 0xAA to address 30 → ignored; reading address 30 → 0; address 23 writes and reads normally.
- Debug back-to-back: dbg_req high for 2 cycles with addresses 1 then 2 (values 0x5, 0x6) → dbg_valid high for 2 cycles with dbg_data 0x5 then 0x6, then dbg_valid low.
